// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// State encodings, the ebreak opcode and the default counter width.
// Imported by the controller top.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Encoding of the ebreak instruction that raises i_wb_ebreak upstream.
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_sat_counter.sv
// Saturating event counter with enable.
// Latency: count visible one cycle after the enabled cycle.
// Backpressure: none; holds at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = (r_cnt == {W{1'b1}});

  // Count enabled cycles, stick at the maximum value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Latency: stage controls are combinational from state and inputs; halt/error registered.
// Backpressure: MDU ops stall the front end until done or timeout; HALT freezes everything.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_use_flag,
  input  logic             i_ex_redirect,
  input  logic             i_ex_mdu_start,
  input  logic             i_mdu_done,
  input  logic             i_wb_ebreak,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_bubble,
  output logic             o_mem_wb_bubble,
  output logic             o_halt,
  output logic             o_err_timeout,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  // Width big enough to hold MDU_TIMEOUT-2, the last count before timing out.
  localparam int TO_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 2);

  state_e          r_state;
  state_e          w_next;
  logic            r_halt;
  logic            r_err;
  logic [TO_W-1:0] r_to_cnt;

  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_flush;
  logic w_ex_mem_bubble;
  logic w_mem_wb_bubble;
  logic w_to_clr;
  logic w_to_inc;
  logic w_to_fire;
  logic w_flush_evt;
  logic w_stall_evt;

  // State register: async reset always lands in RUN, dropping any pending MDU wait.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-stage control decode; RUN rows are strictly prioritised.
  always_comb begin
    w_next          = r_state;
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_to_clr        = 1'b0;
    w_to_inc        = 1'b0;
    w_to_fire       = 1'b0;
    w_flush_evt     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_wb_ebreak) begin
          // The ebreak itself retires; the freeze starts next cycle.
          w_next = ST_HALT;
        end else if (i_ex_redirect) begin
          // PC loads the target; wrong-path instructions in IF/ID and ID are killed.
          // Flushing ID/EX also covers any concurrent load-use bubble.
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_flush_evt   = 1'b1;
        end else if (i_ex_mdu_start && !i_mdu_done) begin
          w_pc_stall      = 1'b1;
          w_if_id_stall   = 1'b1;
          w_id_ex_stall   = 1'b1;
          w_ex_mem_bubble = 1'b1;
          w_to_clr        = 1'b1;
          w_next          = ST_MDU_WAIT;
        end else if (i_ex_mdu_start && i_mdu_done) begin
          // Single-cycle completion: the op moves on like any ALU op.
          w_next = ST_RUN;
        end else if (i_load_use_flag) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        // Redirect, load-use and ebreak cannot legally arrive while EX is occupied.
        if (i_mdu_done) begin
          w_next = ST_RUN;
        end else begin
          w_pc_stall      = 1'b1;
          w_if_id_stall   = 1'b1;
          w_id_ex_stall   = 1'b1;
          w_ex_mem_bubble = 1'b1;
          w_to_inc        = 1'b1;
          if (r_to_cnt == TO_LAST) begin
            w_to_fire = 1'b1;
            w_next    = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        w_pc_stall      = 1'b1;
        w_if_id_stall   = 1'b1;
        w_id_ex_stall   = 1'b1;
        w_ex_mem_bubble = 1'b1;
        w_mem_wb_bubble = 1'b1;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // MDU wait timer: cleared on entry, advanced on every cycle still waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (w_to_clr) begin
      r_to_cnt <= '0;
    end else if (w_to_inc && (r_to_cnt != TO_LAST)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Halt tracks entry into HALT so it is high from the first HALT cycle; timeout is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_halt <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_halt <= (w_next == ST_HALT);
      r_err  <= r_err | w_to_fire;
    end
  end

  // Only stalls caused by live hazards are counted, not the HALT freeze.
  assign w_stall_evt = w_pc_stall && ((r_state == ST_RUN) || (r_state == ST_MDU_WAIT));

  perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_stall_evt),
    .o_cnt (o_stall_cycles)
  );

  perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_flush_evt),
    .o_cnt (o_flush_events)
  );

  assign o_pc_stall      = w_pc_stall;
  assign o_if_id_stall   = w_if_id_stall;
  assign o_if_id_flush   = w_if_id_flush;
  assign o_id_ex_stall   = w_id_ex_stall;
  assign o_id_ex_flush   = w_id_ex_flush;
  assign o_ex_mem_bubble = w_ex_mem_bubble;
  assign o_mem_wb_bubble = w_mem_wb_bubble;
  assign o_halt          = r_halt;
  assign o_err_timeout   = r_err;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MDU_TIMEOUT=8, 4-bit counters).
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
// Each scenario task starts from a fresh reset.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_use = 1'b0;
  logic          redirect = 1'b0;
  logic          mdu_start = 1'b0;
  logic          mdu_done = 1'b0;
  logic          ebreak = 1'b0;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_bubble, mem_wb_bubble, halt, err_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [6:0]    ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(CW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load_use_flag (load_use),
    .i_ex_redirect   (redirect),
    .i_ex_mdu_start  (mdu_start),
    .i_mdu_done      (mdu_done),
    .i_wb_ebreak     (ebreak),
    .o_pc_stall      (pc_stall),
    .o_if_id_stall   (if_id_stall),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_stall   (id_ex_stall),
    .o_id_ex_flush   (id_ex_flush),
    .o_ex_mem_bubble (ex_mem_bubble),
    .o_mem_wb_bubble (mem_wb_bubble),
    .o_halt          (halt),
    .o_err_timeout   (err_timeout),
    .o_state         (state),
    .o_stall_cycles  (stall_cycles),
    .o_flush_events  (flush_events)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, mem_wb_bubble}
  assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_bubble, mem_wb_bubble};

  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LU    = 7'b110_0100;
  localparam logic [6:0] C_REDIR = 7'b001_0100;
  localparam logic [6:0] C_MDU   = 7'b110_1010;
  localparam logic [6:0] C_HALT  = 7'b110_1011;

  // Redirect or ebreak while an MDU op occupies EX is illegal stimulus.
  always @(negedge clk) begin
    if (!rst && state == 2'd1 && (redirect || ebreak)) begin
      n_fail++;
      $display("FAIL protocol: redirect=%0b ebreak=%0b in MDU_WAIT, required 0", redirect, ebreak);
    end
  end

  task automatic clear_inputs();
    load_use = 0; redirect = 0; mdu_start = 0; mdu_done = 0; ebreak = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({state, halt, err_timeout, stall_cycles, flush_events} !== {2'd0, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d halt=%0b err=%0b stall=%0d flush=%0d, required all 0",
               state, halt, err_timeout, stall_cycles, flush_events);
    end
    step();
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE || state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_ctrl: ctrl=%b state=%0d, required %b state 0", ctrl, state, C_NONE);
    end
    n_tests++;
    if (stall_cycles !== 4'd0 || flush_events !== 4'd0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_counters: stall=%0d flush=%0d halt=%0b, required 0 0 0",
               stall_cycles, flush_events, halt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step();
    load_use = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_LU) begin
      n_fail++;
      $display("FAIL load_use_ctrl: ctrl=%b, required %b", ctrl, C_LU);
    end
    step();
    load_use = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE || stall_cycles !== 4'd1) begin
      n_fail++;
      $display("FAIL load_use_after: ctrl=%b stall=%0d, required %b stall 1", ctrl, stall_cycles, C_NONE);
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    step();
    redirect = 1'b1;
    load_use = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_REDIR) begin
      n_fail++;
      $display("FAIL redirect_ctrl: ctrl=%b, required %b", ctrl, C_REDIR);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (flush_events !== 4'd1 || stall_cycles !== 4'd0) begin
      n_fail++;
      $display("FAIL redirect_counters: flush=%0d stall=%0d, required 1 0", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mdu();
    do_reset();
    step();
    mdu_start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_MDU || state !== 2'd0) begin
      n_fail++;
      $display("FAIL mdu_start: ctrl=%b state=%0d, required %b state 0", ctrl, state, C_MDU);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      mdu_start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ctrl !== C_MDU || state !== 2'd1) begin
        n_fail++;
        $display("FAIL mdu_wait_%0d: ctrl=%b state=%0d, required %b state 1", k, ctrl, state, C_MDU);
      end
    end
    step();
    mdu_done = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE || state !== 2'd1) begin
      n_fail++;
      $display("FAIL mdu_done: ctrl=%b state=%0d, required %b state 1", ctrl, state, C_NONE);
    end
    step();
    mdu_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 4'd5 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL mdu_release: state=%0d stall=%0d err=%0b, required 0 5 0", state, stall_cycles, err_timeout);
    end
    // Stray done in RUN without a start is ignored; start+done together is single-cycle.
    step();
    mdu_done = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE) begin
      n_fail++;
      $display("FAIL stray_done: ctrl=%b, required %b", ctrl, C_NONE);
    end
    step();
    mdu_start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE) begin
      n_fail++;
      $display("FAIL mdu_single_cycle: ctrl=%b, required %b", ctrl, C_NONE);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 4'd5) begin
      n_fail++;
      $display("FAIL mdu_single_after: state=%0d stall=%0d, required 0 5", state, stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    // Six more waiting cycles; the seventh waiting cycle triggers the timeout.
    repeat (6) step();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd1 || err_timeout !== 1'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_last_wait: state=%0d err=%0b halt=%0b, required 1 0 0", state, err_timeout, halt);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd2 || err_timeout !== 1'b1 || halt !== 1'b1 || ctrl !== C_HALT) begin
      n_fail++;
      $display("FAIL timeout_fire: state=%0d err=%0b halt=%0b ctrl=%b, required 2 1 1 %b",
               state, err_timeout, halt, ctrl, C_HALT);
    end
    n_tests++;
    if (stall_cycles !== 4'd8) begin
      n_fail++;
      $display("FAIL timeout_stalls: stall=%0d, required 8", stall_cycles);
    end
    step();
    load_use = 1'b1;
    mdu_done = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd2 || halt !== 1'b1 || err_timeout !== 1'b1 || stall_cycles !== 4'd8) begin
      n_fail++;
      $display("FAIL halt_sticky: state=%0d halt=%0b err=%0b stall=%0d, required 2 1 1 8",
               state, halt, err_timeout, stall_cycles);
    end
    do_reset();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || halt !== 1'b0 || err_timeout !== 1'b0 || ctrl !== C_NONE) begin
      n_fail++;
      $display("FAIL halt_exit_reset: state=%0d halt=%0b err=%0b ctrl=%b, required 0 0 0 %b",
               state, halt, err_timeout, ctrl, C_NONE);
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    step();
    ebreak = 1'b1;
    redirect = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE || halt !== 1'b0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL ebreak_retire: ctrl=%b halt=%0b state=%0d, required %b 0 0", ctrl, halt, state, C_NONE);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (halt !== 1'b1 || state !== 2'd2 || ctrl !== C_HALT || flush_events !== 4'd0) begin
      n_fail++;
      $display("FAIL ebreak_halt: halt=%0b state=%0d ctrl=%b flush=%0d, required 1 2 %b 0",
               halt, state, ctrl, flush_events, C_HALT);
    end
    n_tests++;
    if (stall_cycles !== 4'd0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ebreak_counters: stall=%0d err=%0b, required 0 0", stall_cycles, err_timeout);
    end
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    step();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mdu: state=%0d stall=%0d flush=%0d, required 0 0 0",
               state, stall_cycles, flush_events);
    end
    #1;
    rst = 1'b0;
    step();
    mdu_done = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_NONE || state !== 2'd0) begin
      n_fail++;
      $display("FAIL late_done: ctrl=%b state=%0d, required %b 0", ctrl, state, C_NONE);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || stall_cycles !== 4'd0) begin
      n_fail++;
      $display("FAIL late_done_after: state=%0d stall=%0d, required 0 0", state, stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Load-use held for three cycles stalls for exactly three cycles.
    step();
    load_use = 1'b1;
    repeat (2) step();
    @(negedge clk);
    n_tests++;
    if (ctrl !== C_LU) begin
      n_fail++;
      $display("FAIL lu_held_ctrl: ctrl=%b, required %b", ctrl, C_LU);
    end
    step();
    load_use = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_cycles !== 4'd3) begin
      n_fail++;
      $display("FAIL lu_held_count: stall=%0d, required 3", stall_cycles);
    end
    // Eighteen redirects saturate the 4-bit flush counter at 15.
    for (int k = 0; k < 18; k++) begin
      step();
      redirect = 1'b1;
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    n_tests++;
    if (flush_events !== 4'd15) begin
      n_fail++;
      $display("FAIL flush_saturate: flush=%0d, required 15", flush_events);
    end
    // Fourteen further load-use stalls push the stall counter from 3 past 15.
    load_use = 1'b1;
    repeat (14) step();
    load_use = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_cycles !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_saturate: stall=%0d, required 15", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_mdu();
    test_timeout();
    test_ebreak();
    test_reset_mid_mdu();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
